// File: rtl/half_adder_pkg.sv
// Shared defaults and helpers for the multi-lane half adder.
package half_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // All-ones value of a w-bit counter, w in 1..32.
    function automatic logic [31:0] satMax(input int unsigned w);
        logic [32:0] full;
        full = (33'd1 << w) - 33'd1;
        return full[31:0];
    endfunction

    localparam logic [31:0] DEFAULT_SAT_MAX = satMax(DEFAULT_CNT_W);

endpackage

// File: rtl/half_adder_cell.sv
// Single combinational half-adder lane.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered array of independent half-adder lanes with a saturating
// count of accepted samples that produced any carry.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             out_valid,
    output logic             carry_any,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(satMax(CNT_W));

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid_q;
    logic             carry_any_q;
    logic [CNT_W-1:0] carry_cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (sum_d[i]),
            .c (carry_d[i])
        );
    end

    // Results hold while idle; only out_valid tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
            carry_any_q <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q       <= sum_d;
                carry_q     <= carry_d;
                carry_any_q <= |carry_d;
                if ((|carry_d) && (carry_cnt_q != CNT_MAX)) begin
                    carry_cnt_q <= carry_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign carry_any = carry_any_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder (4 lanes, 2-bit counter).
module tb_half_adder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic             out_valid;
    logic             carry_any;
    logic [CNT_W-1:0] carry_cnt;

    int testsRun  = 0;
    int testsFail = 0;

    half_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .sum       (sum),
        .carry     (carry),
        .out_valid (out_valid),
        .carry_any (carry_any),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [WIDTH-1:0] expSum,
                            input logic [WIDTH-1:0] expCarry, input logic expValid,
                            input logic expAny, input logic [CNT_W-1:0] expCnt);
        checkOutput({tag, ".sum"},       32'(sum),       32'(expSum));
        checkOutput({tag, ".carry"},     32'(carry),     32'(expCarry));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(expValid));
        checkOutput({tag, ".carry_any"}, 32'(carry_any), 32'(expAny));
        checkOutput({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(expCnt));
    endtask

    initial begin
        logic [1:0] abVec [4];
        logic [1:0] scVec [4];
        logic [CNT_W-1:0] satExp [5];
        abVec  = '{2'b00, 2'b01, 2'b10, 2'b11};
        scVec  = '{2'b00, 2'b10, 2'b10, 2'b01};
        satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        checkAll("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

        // Exhaustive truth table on lane 0, other lanes idle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, {3'b000, abVec[i][1]}, {3'b000, abVec[i][0]});
            checkAll($sformatf("truth%0d", i), {3'b000, scVec[i][1]},
                     {3'b000, scVec[i][0]}, 1'b1, scVec[i][0], (i == 3) ? 2'd1 : 2'd0);
        end

        // Hold: idle cycles keep results and do not count, even with carries on a/b.
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0001);
        checkAll("holdLoad", 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
        checkAll("holdIdle", 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
        checkAll("holdIdleCarry", 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd1);

        // Multi-lane: no carry propagation between lanes.
        applyStimulus(1'b0, 1'b1, 4'b1100, 4'b1010);
        checkAll("multiLane", 4'b0110, 4'b1000, 1'b1, 1'b1, 2'd2);
        applyStimulus(1'b0, 1'b1, 4'b0101, 4'b1010);
        checkAll("multiNoCarry", 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd2);

        // Saturation of the 2-bit counter.
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0001);
            checkOutput($sformatf("sat%0d", i), 32'(carry_cnt), 32'(satExp[i]));
        end

        // Reset overrides a simultaneous valid sample, then recovery.
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
        checkAll("rstOverride", 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
        checkAll("afterRst", 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent half-adder lanes, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the carry-event counter, legal range 1..32.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port a, input, WIDTH bits: addend A, one bit per lane.
REQ-006 Port b, input, WIDTH bits: addend B, one bit per lane.
REQ-007 Port in_valid, input, 1 bit: a/b are sampled when in_valid=1.
REQ-008 Port sum, output, WIDTH bits: registered per-lane sum, a XOR b.
REQ-009 Port carry, output, WIDTH bits: registered per-lane carry, a AND b.
REQ-010 Port out_valid, output, 1 bit: sum/carry hold a new result this cycle.
REQ-011 Port carry_any, output, 1 bit: registered OR-reduction of carry.
REQ-012 Port carry_cnt, output, CNT_W bits: saturating count of accepted samples with carry_any=1.

Function
REQ-013 Per lane i: sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]; lanes are independent, with no carry propagation between lanes.
REQ-014 Latency is exactly 1 cycle: a sample accepted at edge N appears on sum/carry/carry_any at edge N+1 (visible after edge N).
REQ-015 When in_valid=1 at a rising edge, sum, carry and carry_any load the new results and out_valid is set to 1.
REQ-016 When in_valid=0 at a rising edge, sum, carry and carry_any hold their previous values and out_valid is set to 0.
REQ-017 There is no backpressure: every in_valid=1 cycle is accepted and nothing is ever dropped.
REQ-018 carry_cnt increments by 1 on each accepted sample whose OR-reduction of a AND b is 1.
REQ-019 carry_cnt saturates at 2^CNT_W-1; further carry samples leave it unchanged, with no wrap-around.
REQ-020 Truth table per lane, as (a,b) -> (sum,carry): 00->00, 01->10, 10->10, 11->01.
REQ-021 Inputs with X/Z values are outside the contract; the design does not need to define behaviour for them.

Reset
REQ-022 While rst=1 at a rising edge, the outputs take these values: sum=0, carry=0, carry_any=0, out_valid=0, carry_cnt=0.
REQ-023 Reset overrides in_valid: a sample presented in the same cycle as rst=1 is discarded and is not counted.
REQ-024 Reset asserted mid-stream clears all state on that edge; the first sample accepted after rst deasserts produces output one cycle later.
REQ-025 Reset is synchronous only; no output changes between clock edges.

Structure
REQ-026 A shared package half_adder_pkg holds the default WIDTH and CNT_W constants and the saturation-max helper constant.
REQ-027 A combinational sub-module ha_cell (inputs a, b; outputs s, c) implements one lane and is instantiated WIDTH times via generate.
REQ-028 Registers, the valid flag, the OR-reduction and the saturating counter reside in half_adder itself.

Verification
REQ-029 Exhaustive 1-bit test (WIDTH=1): apply (a,b) = 00, 01, 10, 11 with in_valid=1 on consecutive cycles -> (sum,carry) = 00, 10, 10, 01 appear one cycle later each, and carry_cnt ends at 1.
REQ-030 Hold test: apply a=1, b=1 with in_valid=1, then a=0, b=0 with in_valid=0 -> sum=0, carry=1 persist, out_valid drops to 0, and carry_cnt stays at 1.
REQ-031 Multi-lane test (WIDTH=4): a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000, carry_any=1.
REQ-032 Saturation test (CNT_W=2): five accepted samples with a=b=1 -> carry_cnt reads 1, 2, 3, 3, 3.
REQ-033 Reset test: assert rst together with in_valid=1, a=b=1 -> the next cycle shows all outputs 0 and carry_cnt=0; after deassert, a=1, b=0 gives sum=1 one cycle later.
